// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide
// step per cycle on operand magnitudes, with sign fix-up and special cases in FIX.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic               r_sign_a, r_sign_b, r_div0;
    logic [WIDTH-1:0]   r_mag_a, r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_c;

    logic               w_accept, w_sgn_a_op, w_sgn_b_op, w_neg_a, w_neg_b, w_ge;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_result;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_sub;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;

    assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_sgn_a_op = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sgn_b_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_neg_a    = w_sgn_a_op && A[WIDTH-1];
    assign w_neg_b    = w_sgn_b_op && B[WIDTH-1];
    assign w_abs_a    = w_neg_a ? -A : A;
    assign w_abs_b    = w_neg_b ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_sub     = w_rem_sh - {1'b0, r_mag_b};
    assign w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_div_nxt = {(w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    // Divide by zero leaves |A| as remainder, so sign fix-up returns A; 0x80000000/-1
    // falls out of the magnitude path as 0x80000000 rem 0 without extra logic.
    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quot = r_div0 ? '1 :
                    ((r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_result = w_prod[WIDTH-1:0];
        case (r_funct3)
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_result = w_quot;
            3'b110, 3'b111:         w_result = w_rem;
            default:                w_result = w_prod[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_CALC;
            S_CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = start ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_c      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_funct3 <= funct3;
                r_sign_a <= w_neg_a;
                r_sign_b <= w_neg_b;
                r_div0   <= (B == '0);
                r_mag_a  <= w_abs_a;
                r_mag_b  <= w_abs_b;
                r_acc    <= funct3[2] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_funct3[2] ? w_div_nxt : w_mul_nxt;
            end
            if (r_state == S_FIX) begin
                r_c <= w_result;
            end
        end
    end

    assign busy = (r_state == S_CALC) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign C    = r_c;

endmodule
